// File: rtl/dp_tile_sequencer.sv
// dp_tile_sequencer: streams L tiles of N elements through an external
// combinational DotProduct and accumulates the per-tile results into a wide
// signed sum, presented on a valid/ready result port.
// Optional build macro: DP_TILE_SEQ_SAT_EN (saturating accumulation + sat_flag).
module dp_tile_sequencer #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 48,
  parameter int MAX_TILES  = 255,
  parameter int LEN_W      = $clog2(MAX_TILES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          cfg_len,
  output logic                      cfg_ready,
  input  logic                      abort,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   in_x,
  input  logic [N*DATA_WIDTH-1:0]   in_w,
  output logic [N*DATA_WIDTH-1:0]   dp_x,
  output logic [N*DATA_WIDTH-1:0]   dp_w,
  input  logic [ACC_WIDTH-1:0]      dp_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [LEN_W-1:0]          tiles_done,
  output logic                      busy
`ifdef DP_TILE_SEQ_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state, state_d;
  logic                         clear_job, load_len, accum, last_tile;
  logic [LEN_W-1:0]             len_q, len_clamped;
  logic signed [OUT_WIDTH-1:0]  acc, acc_next, dp_ext;

  // The datapath is combinational: operands pass straight through and the
  // result is consumed in the same cycle as the tile handshake.
  assign dp_x = in_x;
  assign dp_w = in_w;

  // Size cast of a signed value sign-extends the tile result to the accumulator.
  assign dp_ext = OUT_WIDTH'(signed'(dp_res));

  assign last_tile = (tiles_done == len_q - LEN_W'(1));
  assign busy      = (state != IDLE);
  assign out_data  = acc;

  // Clamp an oversized tile count to the largest legal job.
  always_comb begin
    len_clamped = cfg_len;
    if ({1'b0, cfg_len} > (LEN_W + 1)'(MAX_TILES)) len_clamped = LEN_W'(MAX_TILES);
  end

`ifdef DP_TILE_SEQ_SAT_EN
  localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH:0] sum_wide;
  logic                      clamp, sat_q;

  // Saturating add: one guard bit detects overflow; once clamped, the sum
  // stays pinned for the remainder of the job.
  always_comb begin
    sum_wide = {acc[OUT_WIDTH-1], acc} + {dp_ext[OUT_WIDTH-1], dp_ext};
    clamp    = sum_wide[OUT_WIDTH] ^ sum_wide[OUT_WIDTH-1];
    acc_next = sum_wide[OUT_WIDTH-1:0];
    if (sat_q)      acc_next = acc;
    else if (clamp) acc_next = sum_wide[OUT_WIDTH] ? MIN_NEG : MAX_POS;
  end

  assign sat_flag = sat_q && (state == DONE);
`else
  assign acc_next = acc + dp_ext;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and handshake decode; abort outranks start and the last tile.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    clear_job = 1'b0;
    load_len  = 1'b0;
    accum     = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start && !abort) begin
          clear_job = 1'b1;
          load_len  = 1'b1;
          state_d   = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (abort) begin
          clear_job = 1'b1;
          state_d   = IDLE;
        end else if (in_valid) begin
          accum = 1'b1;
          if (last_tile) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort) begin
          clear_job = 1'b1;
          state_d   = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job registers: cleared on start/abort, updated on each accepted tile,
  // otherwise held (including after the result has been consumed).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      tiles_done <= '0;
      len_q      <= '0;
`ifdef DP_TILE_SEQ_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else if (clear_job) begin
      acc        <= '0;
      tiles_done <= '0;
      if (load_len) len_q <= len_clamped;
`ifdef DP_TILE_SEQ_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else if (accum) begin
      acc        <= acc_next;
      tiles_done <= tiles_done + LEN_W'(1);
`ifdef DP_TILE_SEQ_SAT_EN
      sat_q      <= sat_q | clamp;
`endif
    end
  end

endmodule

// File: tb/tb_dp_tile_sequencer.sv
// Self-checking bench for dp_tile_sequencer: a default-width instance and a
// 20-bit-result instance share all stimulus; a behavioural DotProduct drives
// dp_res. Honours DP_TILE_SEQ_SAT_EN when the design is built with it.
module tb_dp_tile_sequencer;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int OW  = 48;
  localparam int OW2 = 20;
  localparam int MT  = 255;
  localparam int LW  = 8;

  typedef logic signed [63:0] val_t;

  typedef struct {
    int               len;
    logic [N*DW-1:0]  x;
    logic [N*DW-1:0]  w;
    val_t             exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, abort, in_valid, out_ready;
  logic [LW-1:0]     cfg_len;
  logic [N*DW-1:0]   in_x, in_w;
  logic              cfg_ready, in_ready, out_valid, busy;
  logic [N*DW-1:0]   dp_x, dp_w;
  logic [AW-1:0]     dp_res;
  logic [OW-1:0]     out_data;
  logic [LW-1:0]     tiles_done;
  logic              cfg_ready2, in_ready2, out_valid2, busy2;
  logic [N*DW-1:0]   dp_x2, dp_w2;
  logic [AW-1:0]     dp_res2;
  logic [OW2-1:0]    out_data2;
  logic [LW-1:0]     tiles_done2;
`ifdef DP_TILE_SEQ_SAT_EN
  logic              sat_flag, sat_flag2;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural DotProduct: signed element products summed.
  function automatic logic [AW-1:0] dot(input logic [N*DW-1:0] x, input logic [N*DW-1:0] w);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(signed'(x[i*DW +: DW])) * int'(signed'(w[i*DW +: DW]));
    return AW'(s);
  endfunction

  assign dp_res  = dot(dp_x, dp_w);
  assign dp_res2 = dot(dp_x2, dp_w2);

  dp_tile_sequencer #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .MAX_TILES(MT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_ready(cfg_ready),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .dp_x(dp_x), .dp_w(dp_w), .dp_res(dp_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .tiles_done(tiles_done), .busy(busy)
`ifdef DP_TILE_SEQ_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  dp_tile_sequencer #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW2), .MAX_TILES(MT)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_ready(cfg_ready2),
    .abort(abort), .in_valid(in_valid), .in_ready(in_ready2), .in_x(in_x), .in_w(in_w),
    .dp_x(dp_x2), .dp_w(dp_w2), .dp_res(dp_res2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .tiles_done(tiles_done2), .busy(busy2)
`ifdef DP_TILE_SEQ_SAT_EN
    , .sat_flag(sat_flag2)
`endif
  );

  function automatic logic [N*DW-1:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Expected result of a 20-bit accumulator for a job whose exact sum is v
  // (exact when no intermediate step overflows in the opposite direction).
  function automatic val_t fit20(input val_t v);
`ifdef DP_TILE_SEQ_SAT_EN
    if (v > 64'sd524287)  return 64'sd524287;
    if (v < -64'sd524288) return -64'sd524288;
    return v;
`else
    val_t t;
    t = v & 64'hF_FFFF;
    if (t >= 64'sd524288) t = t - 64'sd1048576;
    return t;
`endif
  endfunction

  task automatic check(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    cfg_len = LW'(len);
    tick();
    start   = 1'b0;
  endtask

  task automatic push(input logic [N*DW-1:0] x, input logic [N*DW-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the last handshake (or the start edge for L=0):
  // the result must already be valid, then held for 'delay' stalled cycles.
  task automatic collect(input string name, input val_t exp, input int tiles, input int delay);
    check({name, "_valid"},   out_valid, 1);
    check({name, "_data"},    signed'(out_data), exp);
    check({name, "_data20"},  signed'(out_data2), fit20(exp));
    check({name, "_tiles"},   tiles_done, tiles);
    check({name, "_busy"},    busy, 1);
    out_ready = 1'b0;
    for (int i = 0; i < delay; i++) begin
      tick();
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_data"},  signed'(out_data), exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drop_valid"}, out_valid, 0);
    check({name, "_cfg_ready"},  cfg_ready, 1);
    check({name, "_retained"},   signed'(out_data), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[5];
    val_t model;
    int   len, gap, dly;
    logic [N*DW-1:0] rx, rw;

    vecs[0] = '{3, pack(1, 2, 3, 4),         pack(1, 1, 1, 1),         64'sd30};
    vecs[1] = '{1, pack(1, 1, 1, 1),         pack(1, 1, 1, 1),         64'sd4};
    vecs[2] = '{2, pack(-1, -2, -3, -4),     pack(2, 2, 2, 2),         -64'sd40};
    vecs[3] = '{0, pack(1, 1, 1, 1),         pack(1, 1, 1, 1),         64'sd0};
    vecs[4] = '{9, pack(127, 127, 127, 127), pack(127, 127, 127, 127), 64'sd580644};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_len = '0; in_x = '0; in_w = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  signed'(out_data), 0);
    check("rst_busy",      busy, 0);
    check("rst_tiles",     tiles_done, 0);
    check("rst_busy20",    busy2, 0);
    check("rst_cfg20",     cfg_ready2, 1);
    check("rst_in_rdy20",  in_ready2, 0);

    // Table of whole jobs, back-to-back tiles.
    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].len);
      for (int t = 0; t < vecs[v].len; t++) push(vecs[v].x, vecs[v].w);
`ifdef DP_TILE_SEQ_SAT_EN
      if (v == 4) begin
        check("ovf_sat_data20", signed'(out_data2), 64'sd524287);
        check("ovf_sat_flag20", sat_flag2, 1);
        check("ovf_sat_flag48", sat_flag, 0);
      end
`else
      if (v == 4) check("ovf_wrap_data20", signed'(out_data2), -64'sd467932);
`endif
      collect($sformatf("vec%0d", v), vecs[v].exp, vecs[v].len, 1);
    end

    // in_valid while IDLE: not accepted, retained result untouched.
    in_valid = 1'b1; in_x = pack(9, 9, 9, 9); in_w = pack(9, 9, 9, 9);
    check("idle_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("idle_acc_hold",   signed'(out_data), 64'sd580644);
    check("idle_tiles_hold", tiles_done, 9);

    // start together with abort in IDLE: stays IDLE.
    start = 1'b1; abort = 1'b1; cfg_len = 8'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy",  busy, 0);
    check("start_abort_cfg",   cfg_ready, 1);
    check("start_abort_acc",   signed'(out_data), 64'sd580644);

    // Gapped tiles and a stalled consumer: -15 + 8 = -7.
    do_start(2);
    push(pack(-5, 0, 0, 0), pack(3, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gap_tiles_hold", tiles_done, 1);
      check("gap_out_valid",  out_valid, 0);
    end
    push(pack(2, 2, 2, 2), pack(1, 1, 1, 1));
    collect("gapped", -64'sd7, 2, 3);

    // Reset mid-job after 2 of 3 tiles.
    do_start(3);
    push(pack(1, 2, 3, 4), pack(1, 1, 1, 1));
    push(pack(1, 2, 3, 4), pack(1, 1, 1, 1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_tiles",     tiles_done, 0);
    check("midrst_out_data",  signed'(out_data), 0);

    // Abort after 2 of 4 tiles, then a clean single-tile job.
    do_start(4);
    push(pack(3, 3, 3, 3), pack(1, 1, 1, 1));
    push(pack(3, 3, 3, 3), pack(1, 1, 1, 1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",      busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_tiles",     tiles_done, 0);
    check("abort_out_data",  signed'(out_data), 0);
    do_start(1);
    push(pack(1, 1, 1, 1), pack(1, 1, 1, 1));
    collect("post_abort", 64'sd4, 1, 0);

    // Abort coinciding with the last tile handshake: no result.
    do_start(1);
    in_valid = 1'b1; in_x = pack(5, 5, 5, 5); in_w = pack(1, 1, 1, 1); abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("abort_last_valid", out_valid, 0);
    check("abort_last_busy",  busy, 0);
    check("abort_last_data",  signed'(out_data), 0);
    tick();
    check("abort_last_valid2", out_valid, 0);

    // Randomized jobs against an arithmetic reference.
    for (int j = 0; j < 40; j++) begin
      len   = $urandom_range(0, 6);
      dly   = $urandom_range(0, 3);
      model = 0;
      do_start(len);
      for (int t = 0; t < len; t++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        rx = $urandom;
        rw = $urandom;
        for (int e = 0; e < N; e++)
          model += val_t'(signed'(rx[e*DW +: DW])) * val_t'(signed'(rw[e*DW +: DW]));
        push(rx, rw);
      end
      collect($sformatf("rnd%0d", j), model, len, dly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
